// File: rtl/stepper_pkg.sv
// stepper_pkg: register map, CTRL bit positions, FSM states and position step helper
package stepper_pkg;
  localparam logic [1:0] ADDR_STEPS = 2'd0;
  localparam logic [1:0] ADDR_HALF  = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_POS   = 2'd3;
  localparam int CTRL_DIR      = 0;
  localparam int CTRL_ABORT    = 1;
  localparam int CTRL_IRQ_EN   = 2;
  localparam int CTRL_DONE_CLR = 3;
  localparam int CTRL_BUSY     = 8;
  localparam int CTRL_DONE     = 9;
  typedef enum logic [1:0] {IDLE, SETUP, HIGH, LOW} state_t;
  function automatic logic [31:0] step_pos(input logic [31:0] pos, input logic dir);
    return dir ? pos + 32'd1 : pos - 32'd1;
  endfunction
endpackage

// File: rtl/stepper_pulse_fsm.sv
// stepper_pulse_fsm: step/dir pulse sequencer with phase, remaining and position counters
//   in:  start/steps/dir_req begin a move, abort ends it, half sets phase length, pos_load/pos_wdata preset position
//   out: step_out, dir_out, busy, done_set (one-cycle pulse at normal completion), remaining, position
module stepper_pulse_fsm
  import stepper_pkg::*;
#(
  parameter int DIR_SETUP = 2,
  parameter int HALF_W    = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [31:0]       steps,
  input  logic [HALF_W-1:0] half,
  input  logic              dir_req,
  input  logic              pos_load,
  input  logic [31:0]       pos_wdata,
  output logic              step_out,
  output logic              dir_out,
  output logic              busy,
  output logic              done_set,
  output logic [31:0]       remaining,
  output logic [31:0]       position
);
  localparam int CW = HALF_W > 8 ? HALF_W : 8;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, half_eff;
  logic [31:0] rem_q, rem_d, pos_q, pos_d;
  logic dir_q, dir_d, step_q, busy_q, phase_end;
  always_comb begin
    half_eff = (half == '0) ? CW'(1) : CW'(half);
    phase_end = cnt_q == CW'(1);
    state_d = state_q;
    cnt_d = cnt_q - CW'(1);
    rem_d = rem_q;
    pos_d = pos_q;
    dir_d = dir_q;
    done_set = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = cnt_q;
        if (start) begin
          state_d = SETUP;
          cnt_d = CW'(DIR_SETUP);
          rem_d = steps;
          dir_d = dir_req;
        end else if (pos_load) pos_d = pos_wdata;
      end
      // rem_q is never 0 in SETUP because a start needs a nonzero count
      SETUP, LOW: if (phase_end) begin
        if (rem_q != '0) begin
          state_d = HIGH;
          cnt_d = half_eff;
          rem_d = rem_q - 32'd1;
          pos_d = step_pos(pos_q, dir_q);
        end else begin
          state_d = IDLE;
          done_set = 1'b1;
        end
      end
      HIGH: if (phase_end) begin
        state_d = LOW;
        cnt_d = half_eff;
      end
      default: state_d = IDLE;
    endcase
    // abort discards any step that would have begun this edge
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
      rem_d = '0;
      pos_d = pos_q;
      done_set = 1'b0;
    end
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      rem_q <= '0;
      pos_q <= '0;
      dir_q <= 1'b0;
      step_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      rem_q <= rem_d;
      pos_q <= pos_d;
      dir_q <= dir_d;
      step_q <= state_d == HIGH;
      busy_q <= state_d != IDLE;
    end
  assign step_out = step_q;
  assign dir_out = dir_q;
  assign busy = busy_q;
  assign remaining = rem_q;
  assign position = pos_q;
endmodule

// File: rtl/stepper_step_gen.sv
// stepper_step_gen: Avalon-MM slave turning step commands into step/dir pulses for one axis
//   Avalon: address, chipselect, write_n, writedata, readdata (registered, 1-cycle latency)
//   Driver: step_out, dir_out; status: busy, irq (done & irq_en), position (to steps-in PIO)
module stepper_step_gen
  import stepper_pkg::*;
#(
  parameter int DIR_SETUP = 2,
  parameter int HALF_W    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        step_out,
  output logic        dir_out,
  output logic        busy,
  output logic        irq,
  output logic [31:0] position
);
  logic [HALF_W-1:0] half_q, half_d;
  logic dir_req_q, dir_req_d, irq_en_q, irq_en_d, done_q, done_d, irq_q, irq_d;
  logic [31:0] readdata_q, readdata_d, remaining, ctrl_rd;
  logic wr, wr_ctrl, start, abort, done_clr, done_set, pos_load;
  always_comb begin
    wr = chipselect & ~write_n;
    wr_ctrl = wr && address == ADDR_CTRL;
    start = wr && address == ADDR_STEPS && !busy && writedata != '0;
    abort = wr_ctrl & writedata[CTRL_ABORT];
    done_clr = wr_ctrl & writedata[CTRL_DONE_CLR];
    pos_load = wr && address == ADDR_POS;
    half_d = (wr && address == ADDR_HALF) ? writedata[HALF_W-1:0] : half_q;
    dir_req_d = wr_ctrl ? writedata[CTRL_DIR] : dir_req_q;
    irq_en_d = wr_ctrl ? writedata[CTRL_IRQ_EN] : irq_en_q;
    done_d = done_set ? 1'b1 : (start | done_clr) ? 1'b0 : done_q;
    irq_d = done_d & irq_en_d;
    ctrl_rd = '0;
    ctrl_rd[CTRL_DIR] = dir_req_q;
    ctrl_rd[CTRL_IRQ_EN] = irq_en_q;
    ctrl_rd[CTRL_BUSY] = busy;
    ctrl_rd[CTRL_DONE] = done_q;
    readdata_d = !chipselect ? '0 :
                 address == ADDR_STEPS ? remaining :
                 address == ADDR_HALF ? 32'(half_q) :
                 address == ADDR_CTRL ? ctrl_rd : position;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      half_q <= '0;
      dir_req_q <= 1'b0;
      irq_en_q <= 1'b0;
      done_q <= 1'b0;
      irq_q <= 1'b0;
      readdata_q <= '0;
    end else begin
      half_q <= half_d;
      dir_req_q <= dir_req_d;
      irq_en_q <= irq_en_d;
      done_q <= done_d;
      irq_q <= irq_d;
      readdata_q <= readdata_d;
    end
  stepper_pulse_fsm #(.DIR_SETUP(DIR_SETUP), .HALF_W(HALF_W)) u_fsm (
    .clk(clk), .reset_n(reset_n), .start(start), .abort(abort), .steps(writedata),
    .half(half_q), .dir_req(dir_req_q), .pos_load(pos_load), .pos_wdata(writedata),
    .step_out(step_out), .dir_out(dir_out), .busy(busy), .done_set(done_set),
    .remaining(remaining), .position(position)
  );
  assign readdata = readdata_q;
  assign irq = irq_q;
endmodule

// File: tb/tb_stepper_step_gen.sv
// tb_stepper_step_gen: table-driven register checks plus move, abort, busy-write and reset sequences
module tb_stepper_step_gen;
  logic clk = 1'b0, reset_n = 1'b0, chipselect = 1'b0, write_n = 1'b1;
  logic [1:0] address = '0;
  logic [31:0] writedata = '0, readdata, position;
  logic step_out, dir_out, busy, irq;
  int checks = 0, failures = 0;
  logic [31:0] sb_q[$];
  typedef struct {
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[8];

  stepper_step_gen dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata), .step_out(step_out),
    .dir_out(dir_out), .busy(busy), .irq(irq), .position(position)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h want=0x%08h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n = 1'b0;
    address = a;
    writedata = d;
    tick;
    chipselect = 1'b0;
    write_n = 1'b1;
  endtask

  task automatic rd(input string name, input logic [1:0] a, input logic [31:0] exp);
    sb_q.push_back(exp);
    chipselect = 1'b1;
    write_n = 1'b1;
    address = a;
    tick;
    chipselect = 1'b0;
    chk(name, readdata, sb_q.pop_front());
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      tick;
      n++;
    end
    chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    logic exp_step;
    logic [31:0] exp_pos;
    vecs[0] = '{2'd1, 32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{2'd1, 32'hABCD_0005, 32'h0000_0005};
    vecs[2] = '{2'd2, 32'h0000_0005, 32'h0000_0005};
    vecs[3] = '{2'd2, 32'h0000_000F, 32'h0000_0005};
    vecs[4] = '{2'd3, 32'h1234_5678, 32'h1234_5678};
    vecs[5] = '{2'd0, 32'h0000_0000, 32'h0000_0000};
    vecs[6] = '{2'd2, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{2'd3, 32'h0000_0000, 32'h0000_0000};

    repeat (3) tick;
    reset_n = 1'b1;
    chk("rst_step", 32'(step_out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_irq", 32'(irq), 0);
    chk("rst_dir", 32'(dir_out), 0);
    chk("rst_pos", position, 0);
    chk("rst_rd", readdata, 0);
    for (int a = 0; a < 4; a++) rd($sformatf("rst_rd_a%0d", a), 2'(a), 32'd0);
    tick;
    chk("rd_cs_low", readdata, 0);

    for (int i = 0; i < 8; i++) begin
      wr(vecs[i].addr, vecs[i].wdata);
      rd($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end
    chk("steps0_not_busy", 32'(busy), 0);

    wr(2'd1, 32'd2);
    wr(2'd2, 32'h1);
    wr(2'd0, 32'd3);
    chk("t2_dir", 32'(dir_out), 1);
    for (int c = 1; c <= 15; c++) begin
      exp_step = c >= 3 && c <= 12 && ((c - 3) % 4) < 2;
      exp_pos = c < 3 ? 0 : c < 7 ? 1 : c < 11 ? 2 : 3;
      chk($sformatf("t2_step_c%0d", c), 32'(step_out), 32'(exp_step));
      chk($sformatf("t2_pos_c%0d", c), position, exp_pos);
      chk($sformatf("t2_busy_c%0d", c), 32'(busy), 32'(c <= 14));
      tick;
    end
    rd("t2_ctrl_done", 2'd2, 32'h201);
    rd("t2_remaining", 2'd0, 32'd0);
    chk("t2_irq_off", 32'(irq), 0);

    wr(2'd2, 32'h4);
    wr(2'd3, 32'd0);
    wr(2'd1, 32'd0);
    wr(2'd0, 32'd2);
    wait_idle(n);
    chk("t3_cycles", 32'(n), 32'd6);
    chk("t3_pos", position, 32'hFFFF_FFFE);
    chk("t3_dir", 32'(dir_out), 0);
    chk("t3_irq", 32'(irq), 1);
    rd("t3_ctrl", 2'd2, 32'h204);
    wr(2'd2, 32'hC);
    chk("t3_irq_clr", 32'(irq), 0);
    rd("t3_ctrl_clr", 2'd2, 32'h4);

    wr(2'd2, 32'h1);
    wr(2'd3, 32'd0);
    wr(2'd1, 32'd4);
    wr(2'd0, 32'd10);
    n = 0;
    while (position != 32'd3 && n < 200) begin
      tick;
      n++;
    end
    chk("t4_reach3", 32'(n < 200), 1);
    chk("t4_step_hi", 32'(step_out), 1);
    wr(2'd2, 32'h3);
    chk("t4_step", 32'(step_out), 0);
    chk("t4_busy", 32'(busy), 0);
    chk("t4_pos", position, 32'd3);
    rd("t4_rem", 2'd0, 32'd0);
    rd("t4_ctrl", 2'd2, 32'h1);
    repeat (20) tick;
    chk("t4_pos_hold", position, 32'd3);
    wr(2'd2, 32'h3);
    chk("t4_idle_abort", 32'(busy), 0);

    wr(2'd3, 32'd0);
    wr(2'd1, 32'd1);
    wr(2'd0, 32'd2);
    wr(2'd0, 32'd5);
    wr(2'd3, 32'd100);
    wr(2'd2, 32'h0);
    chk("t5_dir_frozen", 32'(dir_out), 1);
    wait_idle(n);
    chk("t5_pos", position, 32'd2);
    rd("t5_rem", 2'd0, 32'd0);
    wr(2'd0, 32'd1);
    chk("t5_newdir", 32'(dir_out), 0);
    wait_idle(n);
    chk("t5_pos2", position, 32'd1);

    wr(2'd3, 32'h7FFF_FFFF);
    wr(2'd2, 32'h1);
    wr(2'd1, 32'd3);
    wr(2'd0, 32'd1);
    n = 0;
    while (!step_out && n < 200) begin
      tick;
      n++;
    end
    chk("t6_pos_wrap", position, 32'h8000_0000);
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_step", 32'(step_out), 0);
    chk("t6_async_busy", 32'(busy), 0);
    chk("t6_async_pos", position, 0);
    #3 reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd($sformatf("t6_rd_a%0d", a), 2'(a), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
